// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM states, bit-time width, and the parity helper
// used by both the receive and transmit engines.
package uart_pkg;
    localparam int K_W = 19;

    typedef enum logic [1:0] {IDLE, START, SHIFT} state_t;

    // Even parity is the XOR of the data bits; odd parity is its inverse.
    function automatic logic par_calc(input logic [7:0] data, input logic eight, input logic ohel);
        logic p;
        p = eight ? ^data : ^data[6:0];
        return ohel ? ~p : p;
    endfunction
endpackage

// File: rtl/uart_bit_timer.sv
// Loadable down-counter for bit timing. Loading L makes tick fire on the
// L-th cycle after the load edge, then the counter holds at zero.
module uart_bit_timer
    import uart_pkg::*;
(
    input  logic           clk,
    input  logic           reset,
    input  logic           load,
    input  logic [K_W-1:0] load_val,
    output logic           tick
);
    logic [K_W-1:0] cnt;

    assign tick = (cnt == '0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            cnt <= '0;
        else if (load)
            cnt <= load_val - K_W'(1);
        else if (cnt != '0)
            cnt <= cnt - K_W'(1);
    end
endmodule

// File: rtl/uart_rx_engine.sv
// UART receive engine: synchronizes rx, finds the start bit, samples each bit
// at mid-bit, and reports the character with parity/framing/overrun status.
module uart_rx_engine
    import uart_pkg::*;
(
    input  logic           clk,
    input  logic           reset,
    input  logic           rx,
    input  logic           eight,
    input  logic           p_en,
    input  logic           ohel,
    input  logic [K_W-1:0] k,
    input  logic           rd,
    output logic [7:0]     rx_data,
    output logic           rxrdy,
    output logic           perr,
    output logic           ferr,
    output logic           ovf
);
    state_t         state, state_nxt;
    logic           rx_s1, rxs;
    logic           cfg_eight, cfg_pen, cfg_ohel;
    logic [K_W-1:0] cfg_k;
    logic [3:0]     bit_cnt, n_bits;
    logic [9:0]     sr, sr_nxt, aligned;
    logic [7:0]     data;
    logic           rx_par, done, tmr_load, tick;
    logic [K_W-1:0] tmr_val;

    uart_bit_timer u_tmr (
        .clk      (clk),
        .reset    (reset),
        .load     (tmr_load),
        .load_val (tmr_val),
        .tick     (tick)
    );

    assign n_bits  = 4'd8 + {3'b0, cfg_eight} + {3'b0, cfg_pen};
    assign sr_nxt  = {rxs, sr[9:1]};
    // After N samples the first data bit sits at bit 10-N; realign to bit 0.
    assign aligned = sr_nxt >> (4'd10 - n_bits);
    assign data    = cfg_eight ? aligned[7:0] : {1'b0, aligned[6:0]};
    assign rx_par  = cfg_eight ? aligned[8] : aligned[7];

    always_comb begin
        state_nxt = state;
        tmr_load  = 1'b0;
        tmr_val   = cfg_k;
        done      = 1'b0;
        case (state)
            IDLE: if (!rxs) begin
                state_nxt = START;
                tmr_load  = 1'b1;
                tmr_val   = k >> 1;
            end
            START: if (tick) begin
                if (rxs) begin
                    state_nxt = IDLE;
                end else begin
                    state_nxt = SHIFT;
                    tmr_load  = 1'b1;
                end
            end
            SHIFT: if (tick) begin
                tmr_load = 1'b1;
                if (bit_cnt == n_bits - 4'd1) begin
                    done      = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_s1     <= 1'b1;
            rxs       <= 1'b1;
            state     <= IDLE;
            cfg_eight <= 1'b0;
            cfg_pen   <= 1'b0;
            cfg_ohel  <= 1'b0;
            cfg_k     <= '0;
            bit_cnt   <= '0;
            sr        <= '0;
        end else begin
            rx_s1 <= rx;
            rxs   <= rx_s1;
            state <= state_nxt;
            if (state == IDLE && !rxs) begin
                cfg_eight <= eight;
                cfg_pen   <= p_en;
                cfg_ohel  <= ohel;
                cfg_k     <= k;
            end
            if (state == START && tick)
                bit_cnt <= '0;
            if (state == SHIFT && tick) begin
                sr      <= sr_nxt;
                bit_cnt <= bit_cnt + 4'd1;
            end
        end
    end

    // Completion beats a same-cycle read; overrun only accrues when unread.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_data <= 8'h00;
            rxrdy   <= 1'b0;
            perr    <= 1'b0;
            ferr    <= 1'b0;
            ovf     <= 1'b0;
        end else if (done) begin
            rx_data <= data;
            rxrdy   <= 1'b1;
            perr    <= cfg_pen & (rx_par != par_calc(data, cfg_eight, cfg_ohel));
            ferr    <= ~rxs;
            ovf     <= rd ? 1'b0 : (ovf | rxrdy);
        end else if (rd) begin
            rxrdy <= 1'b0;
            perr  <= 1'b0;
            ferr  <= 1'b0;
            ovf   <= 1'b0;
        end
    end
endmodule
